// File: rtl/piece_ctrl.sv
// Active-piece controller: picks the next block, sequences spawn/move/
// rotate/gravity requests through a check handshake, locks pieces and
// flags game over.
// Ports: clk, rst_n (sync, active-low); start, tick, move_l, move_r, rot
// request pulses; chk_ack/chk_hit checker reply; chk_req + cand_x/y/rot
// candidate; block_num, rotate, pos_x, pos_y committed piece; lock_pulse,
// piece_cnt, game_over status.
// Macro PIECE_LFSR_EN: random piece order from an 8-bit LFSR; when
// undefined the piece index simply cycles 0..4.
module piece_ctrl #(
   parameter int BOARD_W = 10,
   parameter int SPAWN_X = 3
`ifdef PIECE_LFSR_EN
   ,
   parameter logic [7:0] LFSR_SEED = 8'hA5
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        tick,
   input  logic        move_l,
   input  logic        move_r,
   input  logic        rot,
   input  logic        chk_ack,
   input  logic        chk_hit,
   output logic        chk_req,
   output logic [3:0]  cand_x,
   output logic [4:0]  cand_y,
   output logic [9:0]  cand_rot,
   output logic [9:0]  block_num,
   output logic [9:0]  rotate,
   output logic [3:0]  pos_x,
   output logic [4:0]  pos_y,
   output logic        lock_pulse,
   output logic [15:0] piece_cnt,
   output logic        game_over
);

   typedef enum logic [2:0] {
      S_IDLE, S_SPAWN, S_READY, S_CHECK, S_LOCK, S_OVER
   } state_t;

   typedef enum logic [1:0] {
      K_SPAWN, K_ROT, K_MOVE, K_TICK
   } kind_t;

   localparam logic [4:0] XW = 5'(BOARD_W);

   state_t      r_state, w_nstate;
   kind_t       r_kind, w_kind;
   logic [2:0]  r_blk, w_blk;
   logic [1:0]  r_rot, w_rot, r_crot, w_crot;
   logic [3:0]  r_x, w_x, r_cx, w_cx;
   logic [4:0]  r_y, w_y, r_cy, w_cy;
   logic        r_req, w_req;
   logic        r_lock, w_lock;
   logic        r_over, w_over;
   logic [15:0] r_cnt, w_cnt;
   // pending requests: [3]=rot [2]=move_l [1]=move_r [0]=tick
   logic [3:0]  r_pend, w_pend, w_clr;
   logic        w_live;
   logic [2:0]  w_pick;
   logic        w_adv;

   assign w_live = (r_state != S_IDLE) && (r_state != S_OVER);
   assign w_adv  = (r_state == S_SPAWN);

`ifdef PIECE_LFSR_EN
   logic [7:0] r_lfsr;
   logic       w_fb;

   assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_pick = (r_lfsr[2:0] > 3'd4) ? r_lfsr[2:0] - 3'd5
                                        : r_lfsr[2:0];

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_lfsr <= LFSR_SEED;
      else if (w_adv)
         r_lfsr <= {r_lfsr[6:0], w_fb};
   end
`else
   logic [2:0] r_seq;
   logic       w_restart;

   // a new game always restarts the piece order at index 0
   assign w_restart = start &&
                      (r_state == S_IDLE || r_state == S_OVER);
   assign w_pick    = r_seq;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_seq <= 3'd0;
      else if (w_restart)
         r_seq <= 3'd0;
      else if (w_adv)
         r_seq <= (r_seq == 3'd4) ? 3'd0 : r_seq + 3'd1;
   end
`endif

   always_comb begin
      w_nstate = r_state;
      w_kind   = r_kind;
      w_blk    = r_blk;
      w_rot    = r_rot;
      w_x      = r_x;
      w_y      = r_y;
      w_crot   = r_crot;
      w_cx     = r_cx;
      w_cy     = r_cy;
      w_req    = r_req;
      w_lock   = 1'b0;
      w_over   = r_over;
      w_cnt    = r_cnt;
      w_clr    = 4'b0000;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nstate = S_SPAWN;
               w_cnt    = 16'd0;
            end
         end
         S_SPAWN: begin
            w_blk    = w_pick;
            w_rot    = 2'd0;
            w_x      = 4'(SPAWN_X);
            w_y      = 5'd0;
            w_crot   = 2'd0;
            w_cx     = 4'(SPAWN_X);
            w_cy     = 5'd0;
            w_kind   = K_SPAWN;
            w_req    = 1'b1;
            w_clr    = 4'b1111;
            w_nstate = S_CHECK;
         end
         S_READY: begin
            w_crot = r_rot;
            w_cx   = r_x;
            w_cy   = r_y;
            if (r_pend[3]) begin
               w_clr[3] = 1'b1;
               w_crot   = r_rot + 2'd1;
               w_kind   = K_ROT;
               w_req    = 1'b1;
               w_nstate = S_CHECK;
            end else if (r_pend[2]) begin
               // at the left wall the request is simply dropped
               w_clr[2] = 1'b1;
               if (r_x != 4'd0) begin
                  w_cx     = r_x - 4'd1;
                  w_kind   = K_MOVE;
                  w_req    = 1'b1;
                  w_nstate = S_CHECK;
               end
            end else if (r_pend[1]) begin
               // guard keeps a corrupt column from wrapping the 4-bit x
               w_clr[1] = 1'b1;
               if ({1'b0, r_x} < XW) begin
                  w_cx     = r_x + 4'd1;
                  w_kind   = K_MOVE;
                  w_req    = 1'b1;
                  w_nstate = S_CHECK;
               end
            end else if (r_pend[0]) begin
               w_clr[0] = 1'b1;
               w_cy     = r_y + 5'd1;
               w_kind   = K_TICK;
               w_req    = 1'b1;
               w_nstate = S_CHECK;
            end
         end
         S_CHECK: begin
            if (chk_ack) begin
               w_req    = 1'b0;
               w_nstate = S_READY;
               if (!chk_hit) begin
                  w_rot = r_crot;
                  w_x   = r_cx;
                  w_y   = r_cy;
               end else if (r_kind == K_SPAWN) begin
                  w_nstate = S_OVER;
                  w_over   = 1'b1;
               end else if (r_kind == K_TICK) begin
                  w_nstate = S_LOCK;
                  w_lock   = 1'b1;
                  w_cnt    = r_cnt + 16'd1;
               end
            end
         end
         S_LOCK: begin
            w_nstate = S_SPAWN;
         end
         S_OVER: begin
            if (start) begin
               w_nstate = S_SPAWN;
               w_over   = 1'b0;
               w_cnt    = 16'd0;
            end
         end
         default: begin
            w_nstate = S_IDLE;
         end
      endcase
      // new pulses are latched even while an older one is issued
      w_pend = (r_pend & ~w_clr) |
               ({rot, move_l, move_r, tick} & {4{w_live}});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_kind  <= K_SPAWN;
         r_blk   <= 3'd0;
         r_rot   <= 2'd0;
         r_x     <= 4'd0;
         r_y     <= 5'd0;
         r_crot  <= 2'd0;
         r_cx    <= 4'd0;
         r_cy    <= 5'd0;
         r_req   <= 1'b0;
         r_lock  <= 1'b0;
         r_over  <= 1'b0;
         r_cnt   <= 16'd0;
         r_pend  <= 4'd0;
      end else begin
         r_state <= w_nstate;
         r_kind  <= w_kind;
         r_blk   <= w_blk;
         r_rot   <= w_rot;
         r_x     <= w_x;
         r_y     <= w_y;
         r_crot  <= w_crot;
         r_cx    <= w_cx;
         r_cy    <= w_cy;
         r_req   <= w_req;
         r_lock  <= w_lock;
         r_over  <= w_over;
         r_cnt   <= w_cnt;
         r_pend  <= w_pend;
      end
   end

   assign chk_req    = r_req;
   assign cand_x     = r_cx;
   assign cand_y     = r_cy;
   assign cand_rot   = {8'd0, r_crot};
   assign block_num  = {7'd0, r_blk};
   assign rotate     = {8'd0, r_rot};
   assign pos_x      = r_x;
   assign pos_y      = r_y;
   assign lock_pulse = r_lock;
   assign piece_cnt  = r_cnt;
   assign game_over  = r_over;

endmodule

// File: doc/piece_ctrl.md
# piece_ctrl

Active-piece controller for the Tetris core. Chooses the next block index, feeds `block_num`/`rotate` to the block-shape lookup, and sequences spawn, move, rotate and gravity-drop requests through a collision-check handshake with the board checker. It locks pieces and signals game over, sitting between the input/gravity logic and the board/shape datapath.

## Interface
- `BOARD_W`, 10, playfield width in cells; legal x range is 0..BOARD_W-1 (checker judges overlap).
- `SPAWN_X`, 3, x column of a newly spawned piece.
- `LFSR_SEED`, 8'hA5, nonzero reset value of the piece LFSR.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  begin game (from IDLE or OVER).
- `tick`  in  1  gravity pulse, one cycle.
- `move_l`, `move_r`, `rot`  in  1 each  user request pulses, one cycle.
- `chk_ack`  in  1  checker result valid for the current candidate.
- `chk_hit`  in  1  candidate collides or is out of bounds (valid with `chk_ack`).
- `chk_req`  out  1  candidate valid, held until `chk_ack`.
- `cand_x` out 4, `cand_y` out 5, `cand_rot` out 10  candidate placement.
- `block_num`  out  10  active piece index, 0..4.
- `rotate`  out  10  committed rotation, 0..3.
- `pos_x` out 4, `pos_y` out 5  committed placement.
- `lock_pulse`  out  1  one-cycle pulse: piece written to board.
- `piece_cnt`  out  16  pieces locked since start (wraps at 65535→0).
- `game_over`  out  1  level, high in OVER.

## Operation
- Reset values: state IDLE, all outputs 0, LFSR = `LFSR_SEED`, pending bits cleared.
- Request latching: each pulse on `rot`/`move_l`/`move_r`/`tick` sets its pending bit in any state except IDLE/OVER; a bit clears when its action is issued. Repeated pulses before issue collapse to one.
- States: IDLE, SPAWN, READY, CHECK, LOCK, OVER.
- IDLE: `start` → SPAWN.
- SPAWN (1 cycle): `block_num` ← next index, `rotate` ← 0, `pos_x` ← `SPAWN_X`, `pos_y` ← 0; candidate = same placement, kind = SPAWN; clear all pending bits; LFSR advances → CHECK.
- READY: issue highest-priority pending action: rot > move_l > move_r > tick. Candidate: rot → `cand_rot` = (`rotate`+1)&3; move_l → `pos_x`−1 (issued only if `pos_x` > 0, else bit just cleared); move_r → `pos_x`+1; tick → `pos_y`+1. None pending → stay.
- CHECK: `chk_req`=1. On `chk_ack`: no hit → commit candidate to `rotate`/`pos_x`/`pos_y`, → READY. Hit: SPAWN → OVER; tick → LOCK; rot/move → discard, → READY.
- LOCK (1 cycle): `lock_pulse`=1, `piece_cnt`+1, → SPAWN.
- OVER: `game_over`=1; `start` → SPAWN and `piece_cnt` ← 0; `game_over` drops on leaving.
- Start from IDLE also zeroes `piece_cnt`.

## Timing
- `chk_req` and `cand_*` registered; valid from the first CHECK cycle, stable until `chk_ack` sampled high.
- `chk_ack` may arrive in the first CHECK cycle (zero-wait checker): commit at that edge, READY next cycle.
- Minimum action latency: pulse → pending (edge 1) → READY issues (edge 2) → committed (edge 3, zero-wait ack).
- Request pulses arriving in the same cycle as an issue are latched, not lost.
- `chk_ack` outside CHECK ignored.
- `rst_n` low at any edge overrides all: IDLE, outputs zero, LFSR reseeded, no `lock_pulse`.

## Configuration
- `PIECE_LFSR_EN` defined: 8-bit Fibonacci LFSR, taps 8,6,5,4, steps once per SPAWN; next index = LFSR[2:0] mod 5.
- Not defined: LFSR omitted; next index cycles 0,1,2,3,4,0,… starting at 0 after reset/start.

## Test plan
- Reset then `start`, zero-wait checker, no hits → `block_num`=first index, `pos_x`=3, `pos_y`=0, `rotate`=0, READY within 3 cycles.
- `rot` ×5 with no hits → `rotate` sequence 1,2,3,0,1; `rot`+`tick` same cycle → rotate committed before `pos_y`+1.
- `pos_x`=0, `move_l` → no `chk_req`, `pos_x` stays 0; `move_r` with `chk_hit`=1 → `pos_x` unchanged.
- `tick` with `chk_hit`=1 at `pos_y`=18 → `lock_pulse` one cycle, `piece_cnt`=1, new piece at (3,0).
- Spawn check returns `chk_hit`=1 → `game_over`=1; `start` → `game_over`=0, `piece_cnt`=0.
- Without `PIECE_LFSR_EN`, 6 locks → `block_num` sequence 0,1,2,3,4,0; `rst_n`=0 mid-CHECK → all outputs 0 next cycle.
